// File: rtl/pipe_reg.sv
// pipe_reg: N-bit, DEPTH-stage elastic pipeline register with per-stage valid bits.
//
// Every stage holds a data word and a valid bit. Words move under a valid/ready
// handshake, and bubbles collapse: a stage advances whenever its successor is empty
// or is itself advancing. Words leave in strict FIFO order.
//
// Parameters:
//   N      data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1); DEPTH = 1 is a single handshaked flop
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high; clears every valid bit and data register
//   flush      synchronous kill of all in-flight entries (data registers keep values)
//   in_valid   upstream presents a word on in
//   in_ready   pipe can accept this cycle (combinational through the advance chain)
//   in         upstream data word
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts this cycle
//   out        last-stage data word
//   occ        number of valid stages (only when PIPE_REG_OCC_EN is defined)
//
// Configuration macro:
//   PIPE_REG_OCC_EN  when defined, adds the registered occupancy counter and port occ.
//                    When undefined, the counter and port are absent; all other
//                    behaviour is unchanged.
//
// Priority of state updates: reset > flush > normal advance. While reset or flush is
// asserted no handshake takes effect, whatever in_ready/out_ready show.

module pipe_reg #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  // ---------------------------------------------------------------------------
  // Stage state
  // ---------------------------------------------------------------------------
  logic [N-1:0]     data_q [DEPTH];
  logic [N-1:0]     data_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;

  // adv[i]: stage i hands its word onward this cycle (to stage i+1, or out).
  // ld[i]:  stage i captures a new word this cycle.
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] ld;

  // ---------------------------------------------------------------------------
  // Advance chain, evaluated from the last stage back towards the input.
  // A running temporary carries adv[i+1] so the vector is never read while it is
  // being built; this keeps the chain a clean combinational ripple.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic a;
    adv          = '0;
    a            = v_q[DEPTH-1] & out_ready;
    adv[DEPTH-1] = a;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      a      = v_q[i] & (~v_q[i+1] | a);
      adv[i] = a;
    end
  end

  // Ready passes straight through a full pipe when the tail is draining, so a
  // full pipe with out_ready=1 still accepts a word every cycle.
  assign in_ready = ~v_q[0] | adv[0];

  // ---------------------------------------------------------------------------
  // Load terms: stage 0 loads from the input, stage i from stage i-1.
  // ---------------------------------------------------------------------------
  always_comb begin
    ld    = '0;
    ld[0] = in_valid & in_ready;
    for (int i = 1; i < int'(DEPTH); i++) begin
      ld[i] = adv[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      data_d[i] = data_q[i];
    end
    v_d = v_q;

    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_d[i] = '0;
      end
      v_d = '0;
    end else if (flush) begin
      // Kill in-flight entries only; data registers hold so out keeps its value.
      v_d = '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ld[i]) begin
          data_d[i] = (i == 0) ? in : data_q[(i == 0) ? 0 : i - 1];
        end
        v_d[i] = ld[i] | (v_q[i] & ~adv[i]);
      end
    end
  end

  // Synchronous reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      data_q[i] <= data_d[i];
    end
    v_q <= v_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out       = data_q[DEPTH-1];
  assign out_valid = v_q[DEPTH-1];

`ifdef PIPE_REG_OCC_EN
  // ---------------------------------------------------------------------------
  // Occupancy counter: tracks the number of set valid bits. Accept and deliver
  // in the same cycle cancel out, so the count never exceeds DEPTH.
  // ---------------------------------------------------------------------------
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [OccW-1:0] occ_q;
  logic [OccW-1:0] occ_d;
  logic            occ_inc;
  logic            occ_dec;

  assign occ_inc = in_valid & in_ready;
  assign occ_dec = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (reset || flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OccW'(occ_inc) - OccW'(occ_dec);
    end
  end

  always_ff @(posedge clk) begin
    occ_q <= occ_d;
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg (N=8, DEPTH=3).
// Reference model: an ordered list of in-flight words, each tagged with its stage
// position. Each cycle the oldest word moves one position forward (or leaves when at
// the last position and out_ready=1); each younger word moves forward unless that
// would land it on its predecessor's new position.

module tb_pipe_reg;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] dout;
`ifdef PIPE_REG_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  pipe_reg #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout)
`ifdef PIPE_REG_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [N-1:0] mq_data[$];   // index 0 = oldest word
  int           mq_pos[$];    // stage position, 0 .. DEPTH-1
  int           np_q[$];      // scratch: proposed new positions
  bit           m_del;
  logic [N-1:0] last_data;    // word most recently loaded into the last stage

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_advance(input bit ordy);
    np_q.delete();
    m_del = 1'b0;
    for (int i = 0; i < mq_pos.size(); i++) begin
      if (i == 0) begin
        if (mq_pos[0] == int'(DEPTH) - 1 && ordy) begin
          m_del = 1'b1;
          np_q.push_back(int'(DEPTH));  // leaves the pipe
        end else begin
          np_q.push_back(min2(mq_pos[0] + 1, int'(DEPTH) - 1));
        end
      end else begin
        np_q.push_back(min2(mq_pos[i] + 1, np_q[i-1] - 1));
      end
    end
  endfunction

  function automatic bit model_in_ready(input bit ordy);
    model_advance(ordy);
    return (mq_pos.size() == 0) || (np_q[np_q.size()-1] > 0);
  endfunction

  function automatic void model_step(input bit iv, input logic [N-1:0] d, input bit ordy,
                                     input bit fl, input bit rs);
    bit ir;
    if (rs) begin
      mq_data.delete();
      mq_pos.delete();
      last_data = '0;
      return;
    end
    if (fl) begin
      mq_data.delete();
      mq_pos.delete();
      return;
    end
    ir = model_in_ready(ordy);
    if (m_del) begin
      void'(mq_data.pop_front());
      void'(mq_pos.pop_front());
      void'(np_q.pop_front());
    end
    for (int i = 0; i < mq_pos.size(); i++) begin
      if (np_q[i] == int'(DEPTH) - 1 && mq_pos[i] != int'(DEPTH) - 1) last_data = mq_data[i];
      mq_pos[i] = np_q[i];
    end
    if (iv && ir) begin
      mq_data.push_back(d);
      mq_pos.push_back(0);
      if (DEPTH == 1) last_data = d;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // One clock cycle: drive at negedge, compare combinational/registered outputs
  // against the model, then advance the model to match the coming posedge.
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit iv, input logic [N-1:0] d, input bit ordy, input bit fl,
                       input bit rs, input bit chk);
    bit exp_ov;
    @(negedge clk);
    in_valid  = iv;
    din       = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    #1;
    if (chk) begin
      exp_ov = (mq_pos.size() > 0) && (mq_pos[0] == int'(DEPTH) - 1);
      check("in_ready", 32'(in_ready), 32'(model_in_ready(ordy)));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("out", 32'(dout), 32'(last_data));
`ifdef PIPE_REG_OCC_EN
      check("occ", 32'(occ), 32'(mq_pos.size()));
`endif
    end
    model_step(iv, d, ordy, fl, rs);
  endtask

  task automatic random_phase(input int cycles, input int p_iv, input int p_or,
                              input int p_fl, input int p_rs);
    for (int c = 0; c < cycles; c++) begin
      cycle($urandom_range(99) < p_iv, N'($urandom), $urandom_range(99) < p_or,
            $urandom_range(999) < p_fl, $urandom_range(999) < p_rs, 1'b1);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;
    last_data = '0;

    // Reset held 2 cycles while a word is offered: nothing accepted, all clear.
    cycle(1'b1, 8'haa, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'haa, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back stream with out_ready=1, then drain.
    cycle(1'b1, 8'haa, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hbb, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hcc, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Fill with out_ready=0 (fourth word refused), then release.
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(i == 0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);

    // Bubble collapse: 0x55, idle, 0x66 with out_ready=0, then drain.
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Fill then flush with a word offered in the flush cycle.
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Stream with toggling out_ready and a one-cycle reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'ha0 + N'(i), i[0], 1'b0, i == 3, 1'b1);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Randomised phases: balanced, backpressure-heavy, drain-heavy.
    random_phase(400, 70, 70, 20, 10);
    random_phase(300, 80, 25, 10, 5);
    random_phase(300, 50, 90, 15, 5);
    random_phase(300, 95, 50, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
